spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, max clk cycles allowed between m_start assertion and m_ss falling.
REQ-002 Port: clk  input  1  single system clock; all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester transfer request, bit i = requester i.
REQ-005 Port: req_din  input  32  requester i byte at bits [8i+7:8i].
REQ-006 Port: req_mode  input  8  requester i SPI mode at bits [2i+1:2i].
REQ-007 Port: gnt  output  4  one-hot grant, held for the whole transaction.
REQ-008 Port: done  output  4  one-cycle completion pulse to the granted requester.
REQ-009 Port: err  output  1  one-cycle timeout pulse, coincident with done.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: m_start  output  1  start level to spi_master.
REQ-012 Port: m_din  output  8  byte to spi_master, registered.
REQ-013 Port: m_mode  output  2  mode to spi_master, registered.
REQ-014 Port: m_ss  input  1  spi_master SS, active-low, synchronous to clk.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
REQ-016 IDLE with any req bit set: next edge SHALL select winner, load gnt, m_din, m_mode, set m_start=1, enter ISSUE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod 4, wrapping 3->0.
REQ-018 ISSUE SHALL last exactly one cycle, then WAIT_LOW, m_start still 1.
REQ-019 WAIT_LOW: on m_ss==0, m_start SHALL drop to 0 next edge and state -> WAIT_HIGH.
REQ-020 WAIT_HIGH: on m_ss==1, state -> DONE.
REQ-021 DONE SHALL last one cycle: done[granted]=1, gnt cleared on exit, state -> IDLE.
REQ-022 Minimum one IDLE cycle SHALL separate consecutive grants; req sampled only in IDLE.
REQ-023 m_din and m_mode SHALL stay constant from ISSUE through DONE regardless of req_din/req_mode changes.
REQ-024 req deasserted mid-transaction SHALL be ignored; transaction completes and done still pulses.
REQ-025 Last-granted pointer SHALL update only in DONE.
REQ-026 m_ss falling and rising in the same WAIT_LOW cycle is impossible; m_ss high during WAIT_LOW SHALL only wait.

Reset
REQ-027 reset SHALL asynchronously force state IDLE, gnt=0, done=0, err=0, busy=0, m_start=0, m_din=0, m_mode=0, timeout count 0.
REQ-028 Last-granted pointer SHALL reset to 3, so requester 0 has first priority.
REQ-029 reset mid-transaction SHALL abort without done/err pulse; m_start low immediately.

Configuration
REQ-030 Macro SPI_ARB_TIMEOUT_EN defined: counter runs in ISSUE/WAIT_LOW; reaching TIMEOUT cycles SHALL force m_start=0, state DONE, err=1 with done pulse.
REQ-031 SPI_ARB_TIMEOUT_EN undefined: no counter, WAIT_LOW waits indefinitely, err tied 0.

Verification
REQ-032 req=4'b0001, req_din[7:0]=8'hA5, mode=2 -> next edge gnt=0001, m_din=A5, m_mode=2, m_start=1; after m_ss low->high, done=0001 one cycle.
REQ-033 req=4'b1111 held -> grants in order 0,1,2,3,0 with one IDLE cycle between each.
REQ-034 req0 dropped and req_din0 changed to 8'h3C during WAIT_HIGH -> m_din stays A5, done[0] still pulses.
REQ-035 SPI_ARB_TIMEOUT_EN, TIMEOUT=64, m_ss held 1 -> after 64 cycles m_start=0, err=1 and done[granted]=1 same cycle.
REQ-036 reset asserted in WAIT_HIGH -> all outputs 0 immediately, no done; after release req=1000|0001 -> requester 0 granted first.

Source files
------------

// File: rtl/spi_arbiter.sv
// ============================================================================
//  Module      : spi_arbiter
//  Description : Four-requester round-robin arbiter in front of a single
//                spi_master. Latches the winner's byte and mode, drives
//                m_start until the master pulls SS low, waits for SS to rise
//                again and then pulses done to the granted requester.
//                Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a
//                transfer whose SS never falls within TIMEOUT cycles (err).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_din,
    input  logic [7:0]  req_mode,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        err,
    output logic        busy,
    output logic        m_start,
    output logic [7:0]  m_din,
    output logic [1:0]  m_mode,
    input  logic        m_ss
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    // A watchdog shorter than one cycle cannot be honoured.
    if (TIMEOUT < 1) begin : g_bad_timeout
        localparam int BAD_TIMEOUT = 1;
    end

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] r_gnt;
    logic [1:0] r_gidx;
    logic [1:0] r_last;
    logic [7:0] r_din;
    logic [1:0] r_mode;
    logic [1:0] w_win_idx;
    logic       w_win_valid;
    logic       w_timeout;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        logic [1:0] cand;
        w_win_idx   = 2'd0;
        w_win_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = r_last + k[1:0];
            if (!w_win_valid && req[cand]) begin
                w_win_idx   = cand;
                w_win_valid = 1'b1;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_to;

    assign w_timeout = (r_state == S_WAIT_LOW) && m_ss && (r_cnt == CW'(TIMEOUT - 1));

    // Count cycles with m_start high; remember whether DONE came from a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE || r_state == S_WAIT_LOW)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (r_state == S_WAIT_LOW)
                r_to <= w_timeout;
            else if (r_state != S_DONE)
                r_to <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_win_valid) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_LOW;
            S_WAIT_LOW:  begin
                if (!m_ss)          w_next = S_WAIT_HIGH;
                else if (w_timeout) w_next = S_DONE;
            end
            S_WAIT_HIGH: if (m_ss) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Grant and payload capture on arbitration; pointer advance on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt  <= 4'd0;
            r_gidx <= 2'd0;
            r_last <= 2'd3;
            r_din  <= 8'd0;
            r_mode <= 2'd0;
        end else if (r_state == S_IDLE && w_win_valid) begin
            r_gnt  <= 4'b0001 << w_win_idx;
            r_gidx <= w_win_idx;
            r_din  <= req_din[{w_win_idx, 3'b000} +: 8];
            r_mode <= req_mode[{w_win_idx, 1'b0} +: 2];
        end else if (r_state == S_DONE) begin
            r_gnt  <= 4'd0;
            r_last <= r_gidx;
        end
    end

    // Output decode from state and captured registers.
    always_comb begin
        gnt     = r_gnt;
        done    = (r_state == S_DONE) ? r_gnt : 4'd0;
`ifdef SPI_ARB_TIMEOUT_EN
        err     = (r_state == S_DONE) && r_to;
`else
        err     = 1'b0;
`endif
        busy    = (r_state != S_IDLE);
        m_start = (r_state == S_ISSUE) || (r_state == S_WAIT_LOW);
        m_din   = r_din;
        m_mode  = r_mode;
    end

endmodule

`default_nettype wire
